sha3_burst_feeder: RTL

Nonce-sweeping job source for `sha3_iterating_pipe6`: the transmitting end of its `gimme`/`sample` burst protocol. It takes one 25-lane template state, a starting nonce and a hash count. It then drives bursts of consecutive-nonce matrices into the pipe's `rowa..rowe` inputs, one matrix per clock, only when the pipe advertises `gimme`. It sits between the AXI job registers and the iterating pipe, and reports the first nonce of every burst so the result collector can attribute `ogood` bursts.

---
 rtl/sha3_burst_feeder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sha3_burst_feeder.sv
// Nonce-sweeping burst source for sha3_iterating_pipe6: one matrix per clock while sampling.
// Define SHA3_FEEDER_ROUNDUP_EN to pad a final partial burst instead of rejecting the job.
module sha3_burst_feeder #(
    parameter int BURST_LEN  = 15,
    parameter int NONCE_LANE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [25*64-1:0]  template,
    input  logic [63:0]       nonce_first,
    input  logic [31:0]       count,
    input  logic              gimme,
    output logic              sample,
    output logic [5*64-1:0]   rowa,
    output logic [5*64-1:0]   rowb,
    output logic [5*64-1:0]   rowc,
    output logic [5*64-1:0]   rowd,
    output logic [5*64-1:0]   rowe,
    output logic [63:0]       burst_nonce,
    output logic              burst_start,
    output logic              busy,
    output logic              done,
    output logic [31:0]       dispatched
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARM     = 2'd1;
    localparam logic [1:0] S_BURST   = 2'd2;
    localparam logic [1:0] S_WAIT_LO = 2'd3;
    localparam int BW = $clog2(BURST_LEN + 1);

    logic [1:0]         state_reg;
    logic [25*64-1:0]   template_reg;
    logic [63:0]        nonce_reg;
    logic [31:0]        remaining_reg;
    logic [BW-1:0]      beat_reg;
    logic               seen_low_reg;
    logic [25*64-1:0]   mat_reg;
    logic               sample_reg;
    logic [63:0]        burst_nonce_reg;
    logic               burst_start_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [31:0]        dispatched_reg;

    logic [25*64-1:0]   mat_next;
    logic               job_ok;
    logic               issue;
    logic               burst_last;

    // Matrix to present: the latched template with the nonce lane substituted.
    genvar gi;
    generate
        for (gi = 0; gi < 25; gi++) begin : g_lane
            if (gi == NONCE_LANE) begin : g_nonce
                assign mat_next[gi*64 +: 64] = nonce_reg;
            end else begin : g_tmpl
                assign mat_next[gi*64 +: 64] = template_reg[gi*64 +: 64];
            end
        end
    endgenerate

`ifdef SHA3_FEEDER_ROUNDUP_EN
    assign job_ok = (count != 32'd0);
`else
    assign job_ok = (count != 32'd0) && ((count % 32'(BURST_LEN)) == 32'd0);
`endif

    assign burst_last = (beat_reg == BW'(BURST_LEN));
    // A matrix goes out on the ARM->BURST edge and on every following edge until the burst is full.
    assign issue = ((state_reg == S_ARM) && gimme) || ((state_reg == S_BURST) && !burst_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            template_reg    <= '0;
            nonce_reg       <= '0;
            remaining_reg   <= '0;
            beat_reg        <= '0;
            seen_low_reg    <= 1'b0;
            mat_reg         <= '0;
            sample_reg      <= 1'b0;
            burst_nonce_reg <= '0;
            burst_start_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            dispatched_reg  <= '0;
        end else begin
            done_reg        <= 1'b0;
            burst_start_reg <= 1'b0;
            sample_reg      <= issue;
            if (issue) begin
                mat_reg        <= mat_next;
                nonce_reg      <= nonce_reg + 64'd1;
                dispatched_reg <= dispatched_reg + 32'd1;
                remaining_reg  <= (remaining_reg == 32'd0) ? 32'd0 : remaining_reg - 32'd1;
            end
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        if (job_ok) begin
                            template_reg   <= template;
                            nonce_reg      <= nonce_first;
                            remaining_reg  <= count;
                            dispatched_reg <= '0;
                            busy_reg       <= 1'b1;
                            state_reg      <= S_ARM;
                        end else begin
                            done_reg <= 1'b1;
                        end
                    end
                end
                S_ARM: begin
                    if (gimme) begin
                        burst_start_reg <= 1'b1;
                        burst_nonce_reg <= nonce_reg;
                        beat_reg        <= BW'(1);
                        state_reg       <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (burst_last) begin
                        seen_low_reg <= 1'b0;
                        state_reg    <= S_WAIT_LO;
                    end else begin
                        beat_reg <= beat_reg + BW'(1);
                    end
                end
                default: begin
                    // Need a full low-then-high handshake from the pipe before the next burst.
                    if (!gimme) begin
                        seen_low_reg <= 1'b1;
                    end else if (seen_low_reg) begin
                        if (remaining_reg != 32'd0) begin
                            state_reg <= S_ARM;
                        end else begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign sample      = sample_reg;
    assign rowa        = mat_reg[0*320 +: 320];
    assign rowb        = mat_reg[1*320 +: 320];
    assign rowc        = mat_reg[2*320 +: 320];
    assign rowd        = mat_reg[3*320 +: 320];
    assign rowe        = mat_reg[4*320 +: 320];
    assign burst_nonce = burst_nonce_reg;
    assign burst_start = burst_start_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign dispatched  = dispatched_reg;

endmodule
